// File: rtl/keygen_key_splitter_pkg.sv
// Shared types and tables for the dilithium KEYGEN output splitter.
//   seg_t        : segment identifier carried on the pk/sk tag outputs
//   order_ent_t  : one step of a core's emission order (segment + destinations)
//   ORDER_HP/LR  : emission order of the high-perf and low-res cores
//   seg_words()  : word count of a segment for a security level and word width
package keygen_split_pkg;

    typedef enum logic [2:0] {
        SEG_RHO = 3'd0,
        SEG_K   = 3'd1,
        SEG_TR  = 3'd2,
        SEG_S1  = 3'd3,
        SEG_S2  = 3'd4,
        SEG_T0  = 3'd5,
        SEG_T1  = 3'd6
    } seg_t;

    typedef struct packed {
        seg_t seg;
        logic to_pk;
        logic to_sk;
    } order_ent_t;

    localparam int unsigned ORDER_MAX    = 8;
    localparam int unsigned ORDER_HP_LEN = 7;
    localparam int unsigned ORDER_LR_LEN = 8;

    // High-perf core: rho is emitted once and feeds both key streams.
    // The last entry is padding and is never reached.
    localparam order_ent_t [0:ORDER_MAX-1] ORDER_HP = '{
        '{SEG_RHO, 1'b1, 1'b1},
        '{SEG_K,   1'b0, 1'b1},
        '{SEG_S1,  1'b0, 1'b1},
        '{SEG_S2,  1'b0, 1'b1},
        '{SEG_T1,  1'b1, 1'b0},
        '{SEG_T0,  1'b0, 1'b1},
        '{SEG_TR,  1'b0, 1'b1},
        '{SEG_RHO, 1'b0, 1'b0}
    };

    // Low-res core: rho is emitted twice, first copy for sk, second for pk.
    localparam order_ent_t [0:ORDER_MAX-1] ORDER_LR = '{
        '{SEG_RHO, 1'b0, 1'b1},
        '{SEG_K,   1'b0, 1'b1},
        '{SEG_TR,  1'b0, 1'b1},
        '{SEG_S1,  1'b0, 1'b1},
        '{SEG_S2,  1'b0, 1'b1},
        '{SEG_T0,  1'b0, 1'b1},
        '{SEG_RHO, 1'b1, 1'b0},
        '{SEG_T1,  1'b1, 1'b0}
    };

    // Segment sizes are held in bytes so the word count follows W.
    function automatic int unsigned seg_words(input seg_t seg,
                                              input int unsigned sec_level,
                                              input int unsigned w);
        int unsigned bytes;
        bytes = 0;
        case (seg)
            SEG_RHO, SEG_K, SEG_TR: bytes = 32;
            SEG_S1: bytes = (sec_level == 2) ? 384  : (sec_level == 3) ? 640  : 672;
            SEG_S2: bytes = (sec_level == 2) ? 384  : 768;
            SEG_T1: bytes = (sec_level == 2) ? 1280 : (sec_level == 3) ? 1920 : 2560;
            SEG_T0: bytes = (sec_level == 2) ? 1664 : (sec_level == 3) ? 2496 : 3328;
            default: bytes = 0;
        endcase
        return (bytes * 8) / w;
    endfunction

endpackage

// File: rtl/keygen_key_splitter_out_slot.sv
// key_out_slot: one-entry valid/ready output register with segment/index tag.
//   clk, rst            : clock, synchronous active-high reset
//   i_load              : capture i_data/i_seg/i_idx this cycle
//   i_data/i_seg/i_idx  : word and tag to capture
//   i_ready             : downstream consumer ready
//   o_valid/o_data/o_seg/o_idx : registered output word and tag
//   o_free              : slot can accept a load this cycle
module key_out_slot
    import keygen_split_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  seg_t         i_seg,
    input  logic [8:0]   i_idx,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output seg_t         o_seg,
    output logic [8:0]   o_idx,
    output logic         o_free
);

    logic         r_valid;
    logic [W-1:0] r_data;
    seg_t         r_seg;
    logic [8:0]   r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_seg   <= SEG_RHO;
            r_idx   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_seg   <= i_seg;
            r_idx   <= i_idx;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_seg   = r_seg;
    assign o_idx   = r_idx;
    assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/keygen_key_splitter.sv
// keygen_key_splitter: routes the KEYGEN output stream of the dilithium core
// into a public-key stream and a secret-key stream, tagging each word with
// its segment id and index within the segment.
//   clk, rst                        : clock, synchronous active-high reset
//   start                           : arm for one key pair (ignored while busy)
//   in_valid/in_ready/in_data       : word stream from the core
//   pk_valid/pk_ready/pk_data/pk_seg/pk_idx : public-key stream (rho, t1)
//   sk_valid/sk_ready/sk_data/sk_seg/sk_idx : secret-key stream
//   busy                            : armed and key pair not yet complete
//   done                            : one-cycle pulse after last word accepted
module keygen_key_splitter
    import keygen_split_pkg::*;
#(
    parameter int unsigned HIGH_PERF = 1,
    parameter int unsigned SEC_LEVEL = 2,
    parameter int unsigned W         = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         pk_valid,
    input  logic         pk_ready,
    output logic [W-1:0] pk_data,
    output logic [2:0]   pk_seg,
    output logic [8:0]   pk_idx,
    output logic         sk_valid,
    input  logic         sk_ready,
    output logic [W-1:0] sk_data,
    output logic [2:0]   sk_seg,
    output logic [8:0]   sk_idx,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEG  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAST_POS = (HIGH_PERF != 0) ? 3'(ORDER_HP_LEN - 1)
                                                       : 3'(ORDER_LR_LEN - 1);

    state_t     r_state;
    logic [2:0] r_seg_pos;
    logic [8:0] r_idx;
    logic       r_busy;
    logic       r_done;

    order_ent_t w_ent;
    logic [8:0] w_seg_len;
    logic       w_pk_free;
    logic       w_sk_free;
    logic       w_in_ready;
    logic       w_accept;
    logic       w_last_word;
    logic       w_last_seg;
    seg_t       w_pk_seg;
    seg_t       w_sk_seg;

    // Sizes depend only on parameters, so this folds to a constant mux.
    function automatic logic [8:0] seg_len(input seg_t s);
        return 9'(seg_words(s, SEC_LEVEL, W));
    endfunction

    assign w_ent       = (HIGH_PERF != 0) ? ORDER_HP[r_seg_pos] : ORDER_LR[r_seg_pos];
    assign w_seg_len   = seg_len(w_ent.seg);
    assign w_last_word = (r_idx == w_seg_len - 9'd1);
    assign w_last_seg  = (r_seg_pos == LAST_POS);

    // A word is taken only when every slot it is destined for can load it;
    // high-perf rho therefore waits for both slots.
    assign w_in_ready = (r_state == S_SEG)
                     && (!w_ent.to_pk || w_pk_free)
                     && (!w_ent.to_sk || w_sk_free);
    assign w_accept   = in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_seg_pos <= '0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_SEG;
                        r_busy    <= 1'b1;
                        r_seg_pos <= '0;
                        r_idx     <= '0;
                    end
                end
                S_SEG: begin
                    if (w_accept) begin
                        if (w_last_word) begin
                            r_idx <= '0;
                            if (w_last_seg) begin
                                r_state   <= S_DONE;
                                r_done    <= 1'b1;
                                r_seg_pos <= '0;
                            end else begin
                                r_seg_pos <= r_seg_pos + 3'd1;
                            end
                        end else begin
                            r_idx <= r_idx + 9'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    key_out_slot #(.W(W)) u_pk_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept && w_ent.to_pk),
        .i_data  (in_data),
        .i_seg   (w_ent.seg),
        .i_idx   (r_idx),
        .i_ready (pk_ready),
        .o_valid (pk_valid),
        .o_data  (pk_data),
        .o_seg   (w_pk_seg),
        .o_idx   (pk_idx),
        .o_free  (w_pk_free)
    );

    key_out_slot #(.W(W)) u_sk_slot (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept && w_ent.to_sk),
        .i_data  (in_data),
        .i_seg   (w_ent.seg),
        .i_idx   (r_idx),
        .i_ready (sk_ready),
        .o_valid (sk_valid),
        .o_data  (sk_data),
        .o_seg   (w_sk_seg),
        .o_idx   (sk_idx),
        .o_free  (w_sk_free)
    );

    assign pk_seg   = w_pk_seg;
    assign sk_seg   = w_sk_seg;
    assign in_ready = w_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
